// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: buffer geometry,
// the {pc, instr} entry carried to decode, and the fetch control states.
package fetch_pkg;
  localparam int FETCH_BUF_DEPTH = 2;
  localparam int INSTR_W         = 32;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port plus the valid/ready delivery port to decode.
// The master side is the fetch unit; the slave side is memory plus decode.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 6
);
  import fetch_pkg::*;

  logic                 imem_req;
  logic [ADDR_W-1:0]    imem_addr;
  logic [INSTR_W-1:0]   imem_rdata;
  logic                 out_valid;
  logic                 out_ready;
  logic [INSTR_W-1:0]   out_instr;
  logic [31:0]          out_pc;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_rdata, out_ready
  );
endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of tagged fetch entries. Flush empties it in one cycle;
// head shows the oldest entry and is meaningful only while count is non-zero.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   push,
  input  fetch_entry_t                           push_entry,
  input  logic                                   pop,
  input  logic                                   flush,
  output logic [$clog2(FETCH_BUF_DEPTH+1)-1:0]   count,
  output fetch_entry_t                           head
);
  localparam int PTR_W = $clog2(FETCH_BUF_DEPTH);
  localparam int CNT_W = $clog2(FETCH_BUF_DEPTH+1);

  fetch_entry_t     entries [FETCH_BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= push_entry;
  end

  assign count = count_q;
  assign head  = entries[rd_ptr];

  // The issue credit keeps pushes away from a full buffer and pops away from an empty one.
  assert property (@(posedge clk) disable iff (!reset_n)
    push |-> (count_q != CNT_W'(FETCH_BUF_DEPTH)));
  assert property (@(posedge clk) disable iff (!reset_n)
    pop |-> (count_q != '0));
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, issues one word read per cycle, tags returned
// words with their PC and hands them to decode through a 2-entry buffer.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          WORDS    = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  instruction_fetch_unit_if.master   bus,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       fault
);
  localparam int ADDR_W = $clog2(WORDS);
  localparam int CNT_W  = $clog2(FETCH_BUF_DEPTH+1);

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             req_vld_p1;
  logic [31:0]      req_pc_p1;
  fetch_entry_t     head;
  fetch_entry_t     last_out_q;
  fetch_entry_t     push_entry;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   credit_used;
  logic             in_fetch;
  logic             redirect_take;
  logic             issue;
  logic             push;
  logic             pop;

  assign in_fetch      = reset_n && (state_q == FETCH);
  assign redirect_take = in_fetch && redirect_valid;

  // Occupancy the buffer could reach once every outstanding read has landed.
  assign credit_used = (CNT_W+1)'(req_vld_p1) + (CNT_W+1)'(count) - (CNT_W+1)'(pop);
  assign issue       = in_fetch && !redirect_valid &&
                       (credit_used < (CNT_W+1)'(FETCH_BUF_DEPTH));

  assign bus.out_valid = in_fetch && !redirect_valid && (count != '0);
  assign pop           = bus.out_valid && bus.out_ready;
  // A response landing in a redirect cycle belongs to the wrong path.
  assign push          = req_vld_p1 && !redirect_take;
  assign push_entry    = '{pc: req_pc_p1, instr: bus.imem_rdata};

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q[ADDR_W+1:2];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          if (redirect_pc[1:0] == 2'b00) pc_d = redirect_pc;
          else                           state_d = FAULT;
        end else if (issue) begin
          pc_d = pc_q + 32'd4;
        end
      end
      FAULT: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // p0 -> p1: request issued, response returns next cycle
  always_ff @(posedge clk) begin
    if (!reset_n) req_vld_p1 <= 1'b0;
    else          req_vld_p1 <= issue;
  end

  always_ff @(posedge clk) begin
    if (issue) req_pc_p1 <= pc_q;
  end

  // p1 -> buffer: tagged response enters the FIFO, head drives decode
  fetch_skid_fifo u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_take),
    .count      (count),
    .head       (head)
  );

  // Remembers what decode last saw so the outputs stay put once the buffer drains.
  always_ff @(posedge clk) begin
    if (!reset_n)          last_out_q <= '0;
    else if (count != '0)  last_out_q <= head;
  end

  assign bus.out_pc    = (count != '0) ? head.pc    : last_out_q.pc;
  assign bus.out_instr = (count != '0) ? head.instr : last_out_q.instr;
  assign fault         = (state_q == FAULT);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: memory word i holds
// 32'h1000_0000+i; decode-side pops are scored against the expected PC stream.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  localparam int WORDS  = 64;
  localparam int ADDR_W = $clog2(WORDS);

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fault;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] mem [WORDS];

  instruction_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .WORDS(WORDS)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr];
  end

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc >> 2) % 32'(WORDS));
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    bus.out_ready = 1'b1;
    redirect_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", bus.imem_req); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h want=0", bus.out_pc); end
    checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h want=0", bus.out_instr); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b want=0", fault); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_pc = 32'h0;
  endtask

  task automatic test_stream();
    int t_req = -1;
    int t_val = -1;
    int popped = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && popped < 10; c++) begin
      @(negedge clk);
      if (bus.imem_req && t_req < 0) t_req = c;
      if (bus.out_valid && t_val < 0) t_val = c;
      if (t_val >= 0 && c > t_val) begin
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream_gap cycle=%0d got=%b want=1", c, bus.out_valid); end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_pc !== exp_pc || bus.out_instr !== exp_instr(exp_pc)) begin
          errors++; $display("FAIL stream_pop got pc=%h instr=%h want pc=%h instr=%h", bus.out_pc, bus.out_instr, exp_pc, exp_instr(exp_pc));
        end
        exp_pc += 4; popped++;
      end
      @(posedge clk); #1;
    end
    checks++; if (t_req < 0 || t_val - t_req != 2) begin errors++; $display("FAIL first_latency got=%0d want=2", t_val - t_req); end
    checks++; if (popped != 10) begin errors++; $display("FAIL stream_count got=%0d want=10", popped); end
  endtask

  task automatic test_stall();
    int reqs = 0;
    int popped = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.imem_req) reqs++;
      if (c >= 3) begin
        checks++;
        if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b1) begin
          errors++; $display("FAIL stall_hold cycle=%0d got req=%b valid=%b want req=0 valid=1", c, bus.imem_req, bus.out_valid);
        end
      end
      @(posedge clk); #1;
    end
    checks++; if (reqs > 2) begin errors++; $display("FAIL stall_reqs got=%0d want<=2", reqs); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc || bus.out_instr !== exp_instr(exp_pc)) begin
        errors++; $display("FAIL stall_release got valid=%b pc=%h instr=%h want valid=1 pc=%h instr=%h", bus.out_valid, bus.out_pc, bus.out_instr, exp_pc, exp_instr(exp_pc));
      end
      if (bus.out_valid) begin exp_pc += 4; popped++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int popped = 0;
    for (int c = 0; c < 300; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc = 32'($urandom_range(0, 127)) * 4;
      @(negedge clk);
      if (redirect_valid) begin
        checks++;
        if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
          errors++; $display("FAIL rand_redirect_quiet got valid=%b req=%b want 0 0", bus.out_valid, bus.imem_req);
        end
        exp_pc = redirect_pc;
      end else if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (bus.out_pc !== exp_pc || bus.out_instr !== exp_instr(exp_pc)) begin
          errors++; $display("FAIL rand_pop got pc=%h instr=%h want pc=%h instr=%h", bus.out_pc, bus.out_instr, exp_pc, exp_instr(exp_pc));
        end
        exp_pc += 4; popped++;
      end
      @(posedge clk); #1;
    end
    redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (popped < 50) begin errors++; $display("FAIL rand_progress got=%0d want>=50", popped); end
  endtask

  task automatic test_redirect();
    logic [31:0] targets [3];
    int popped = 0;
    targets[0] = 32'h20; targets[1] = 32'h40; targets[2] = 32'h80;
    for (int r = 0; r < 3; r += 2) begin
      bus.out_ready = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      // r=0: single redirect; r=2: back-to-back pair, the last one wins
      for (int k = (r == 0 ? 0 : 1); k <= r; k++) begin
        redirect_valid = 1'b1;
        redirect_pc = targets[k];
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
          errors++; $display("FAIL redirect_quiet got valid=%b req=%b want 0 0", bus.out_valid, bus.imem_req);
        end
        @(posedge clk); #1;
      end
      redirect_valid = 1'b0;
      bus.out_ready = 1'b1;
      exp_pc = targets[r];
      popped = 0;
      for (int c = 0; c < 20 && popped < 6; c++) begin
        @(negedge clk);
        if (bus.out_valid) begin
          checks++;
          if (bus.out_pc !== exp_pc || bus.out_instr !== exp_instr(exp_pc)) begin
            errors++; $display("FAIL redirect_pop got pc=%h instr=%h want pc=%h instr=%h", bus.out_pc, bus.out_instr, exp_pc, exp_instr(exp_pc));
          end
          exp_pc += 4; popped++;
        end
        @(posedge clk); #1;
      end
      checks++; if (popped != 6) begin errors++; $display("FAIL redirect_count got=%0d want=6", popped); end
    end
  endtask

  task automatic test_wrap();
    bit seen = 0;
    bus.out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_00F8;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    exp_pc = 32'h0000_00F8;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c < 3) begin
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== ADDR_W'((62 + c) % WORDS)) begin
          errors++; $display("FAIL wrap_addr got req=%b addr=%0d want req=1 addr=%0d", bus.imem_req, bus.imem_addr, (62 + c) % WORDS);
        end
      end
      if (bus.out_valid) begin
        checks++;
        if (bus.out_pc !== exp_pc || bus.out_instr !== exp_instr(exp_pc)) begin
          errors++; $display("FAIL wrap_pop got pc=%h instr=%h want pc=%h instr=%h", bus.out_pc, bus.out_instr, exp_pc, exp_instr(exp_pc));
        end
        if (bus.out_pc === 32'h100 && bus.out_instr === 32'h1000_0000) seen = 1;
        exp_pc += 4;
      end
      @(posedge clk); #1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL wrap_seen got=0 want=1"); end
  endtask

  task automatic test_reset_mid();
    int popped = 0;
    bus.out_ready = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_quiet got req=%b valid=%b want 0 0", bus.imem_req, bus.out_valid);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0 || fault !== 1'b0) begin
      errors++; $display("FAIL midreset_outs got valid=%b pc=%h instr=%h fault=%b want 0 0 0 0", bus.out_valid, bus.out_pc, bus.out_instr, fault);
    end
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== '0) begin
      errors++; $display("FAIL midreset_restart got req=%b addr=%0d want req=1 addr=0", bus.imem_req, bus.imem_addr);
    end
    @(posedge clk); #1;
    exp_pc = 32'h0;
    for (int c = 0; c < 20 && popped < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        checks++;
        if (bus.out_pc !== exp_pc || bus.out_instr !== exp_instr(exp_pc)) begin
          errors++; $display("FAIL midreset_pop got pc=%h instr=%h want pc=%h instr=%h", bus.out_pc, bus.out_instr, exp_pc, exp_instr(exp_pc));
        end
        exp_pc += 4; popped++;
      end
      @(posedge clk); #1;
    end
    checks++; if (popped != 5) begin errors++; $display("FAIL midreset_count got=%0d want=5", popped); end
  endtask

  task automatic test_misaligned();
    bus.out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0022;
    @(negedge clk);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL misalign_early got=%b want=0", fault); end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) begin redirect_valid = 1'b1; redirect_pc = 32'h0000_0040; end
      if (c == 6) redirect_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL misalign_hold cycle=%0d got fault=%b req=%b valid=%b want 1 0 0", c, fault, bus.imem_req, bus.out_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = 32'h1000_0000 + 32'(i);
    bus.out_ready = 1'b1;
    bus.imem_rdata = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_random();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_misaligned();
    test_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
